// File: rtl/multdiv_ctrl_if.sv
// Handshake/bus bundle between the execute stage and the multiply/divide sequencer.
// The requester owns the operands and start pulses; the sequencer owns the result side.
interface multdiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  // Requester side (execute stage / testbench)
  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  // Sequencer side
  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed multiply / divide sequencer.
// Multiply: radix-2 shift-add on magnitudes. Divide: restoring division on magnitudes.
// Every iteration add/subtract goes through one shared ALU; sign fix-up uses
// dedicated negators in the FIX state. Fixed latency: RDY after the 33rd edge
// following the accepted start edge.

// Shared adder/subtractor used by the iteration step.
// opcode 5'b00000 = add, 5'b00001 = subtract (any other code adds).
module multdiv_alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       opcode_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o   // add: carry out; subtract: 1 means no borrow
);
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Subtract is a + ~b + 1 so the carry out doubles as the "no borrow" flag.
  always_comb begin
    is_sub   = (opcode_i == 5'b00001);
    b_eff    = is_sub ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    result_o = sum[WIDTH-1:0];
    carry_o  = sum[WIDTH];
  end
endmodule

module multdiv_ctrl #(
  parameter int WIDTH = 32,  // only 32 is supported
  parameter int ITER  = 32   // iteration cycles per operation
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_ctrl_if.slave mdu
);
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [5:0] CNT_LAST = 6'(ITER - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [5:0]       cnt_q, cnt_d;
  logic             op_mult_q, op_mult_d;
  logic [WIDTH-1:0] a_q, a_d;          // raw operands, kept for signs and special cases
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] addend_q, addend_d; // |A| for multiply, |B| for divide
  logic [WIDTH-1:0] p_q, p_d;          // product high word / partial remainder
  logic [WIDTH-1:0] q_q, q_d;          // multiplier shift reg / quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic             start;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [WIDTH-1:0] r_shift, q_shift;
  logic [WIDTH-1:0] alu_a, alu_res;
  logic [4:0]       alu_op;
  logic             alu_carry;
  logic [WIDTH-1:0] iter_p, iter_q;
  logic             mult_carry;
  logic [WIDTH-1:0] mult_sum;
  logic             neg_res;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0] quo_signed;
  logic             mult_ovf;
  logic             div_by_zero, div_ovf;

  // A start is accepted only from IDLE or DONE; multiply wins a tie.
  always_comb begin
    start = ((state_q == IDLE) || (state_q == DONE)) && (mdu.ctrl_MULT || mdu.ctrl_DIV);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready pulse and ALU operation select.
  always_comb begin
    mdu.data_resultRDY = (state_q == DONE);
    alu_op             = op_mult_q ? ALU_ADD : ALU_SUB;
  end

  // Dedicated negators producing operand magnitudes; 0x80000000 maps to itself (unsigned).
  always_comb begin
    mag_a_in = mdu.data_operandA[WIDTH-1] ? (~mdu.data_operandA + 1'b1) : mdu.data_operandA;
    mag_b_in = mdu.data_operandB[WIDTH-1] ? (~mdu.data_operandB + 1'b1) : mdu.data_operandB;
  end

  // Operand routing into the shared ALU: P + |A| for multiply, shifted R - |B| for divide.
  always_comb begin
    r_shift = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
    q_shift = {q_q[WIDTH-2:0], 1'b0};
    alu_a   = op_mult_q ? p_q : r_shift;
  end

  multdiv_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (alu_a),
    .b_i      (addend_q),
    .opcode_i (alu_op),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  // One iteration step of the selected algorithm.
  always_comb begin
    mult_carry = q_q[0] ? alu_carry : 1'b0;
    mult_sum   = q_q[0] ? alu_res   : p_q;
    if (op_mult_q) begin
      // shift {carry, P, Q} right by one
      iter_p = {mult_carry, mult_sum[WIDTH-1:1]};
      iter_q = {mult_sum[0], q_q[WIDTH-1:1]};
    end else if (alu_carry) begin
      // trial subtraction did not borrow: keep it and set the quotient bit
      iter_p = alu_res;
      iter_q = {q_shift[WIDTH-1:1], 1'b1};
    end else begin
      // restore the shifted remainder
      iter_p = r_shift;
      iter_q = q_shift;
    end
  end

  // Sign correction and exception detection, consumed in FIX.
  always_comb begin
    neg_res     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    prod_signed = neg_res ? (~{p_q, q_q} + 1'b1) : {p_q, q_q};
    quo_signed  = neg_res ? (~q_q + 1'b1) : q_q;
    // product fits in WIDTH bits only if the top WIDTH+1 bits are a pure sign extension
    mult_ovf    = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    div_by_zero = (b_q == '0);
    div_ovf     = (a_q == MIN_NEG) && (b_q == '1);
  end

  // Datapath next-state: load on start, iterate in RUN, publish result in FIX.
  always_comb begin
    op_mult_d = op_mult_q;
    a_d       = a_q;
    b_d       = b_q;
    addend_d  = addend_q;
    p_d       = p_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    exc_d     = exc_q;
    if (start) begin
      op_mult_d = mdu.ctrl_MULT;
      a_d       = mdu.data_operandA;
      b_d       = mdu.data_operandB;
      addend_d  = mdu.ctrl_MULT ? mag_a_in : mag_b_in;
      p_d       = '0;
      q_d       = mdu.ctrl_MULT ? mag_b_in : mag_a_in;
      cnt_d     = '0;
      result_d  = '0;
      exc_d     = 1'b0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 6'd1;
      p_d   = iter_p;
      q_d   = iter_q;
    end else if (state_q == FIX) begin
      if (op_mult_q) begin
        result_d = prod_signed[WIDTH-1:0];
        exc_d    = mult_ovf;
      end else begin
        result_d = div_by_zero ? '0 : quo_signed;
        exc_d    = div_by_zero || div_ovf;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_mult_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      addend_q  <= '0;
      p_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
    end else begin
      op_mult_q <= op_mult_d;
      a_q       <= a_d;
      b_q       <= b_d;
      addend_q  <= addend_d;
      p_q       <= p_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
    end
  end

  // Held result outputs.
  always_comb begin
    mdu.data_result    = result_q;
    mdu.data_exception = exc_q;
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: expected results are queued at start
// and compared (value, exception, arrival cycle) when the ready pulse appears.
module tb_multdiv_ctrl;
  logic clock;
  logic reset;
  int   cyc;
  int   n_asserts;
  int   n_fail;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  multdiv_ctrl_if mdu_if ();

  multdiv_ctrl dut (
    .clock (clock),
    .reset (reset),
    .mdu   (mdu_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model built on native signed arithmetic.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    logic signed [63:0] p;
    logic signed [31:0] qs;
    if (is_mult) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      r = p[31:0];
      e = !((&p[63:31]) || !(|p[63:31]));
    end else if (b == 32'h0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      qs = $signed(a) / $signed(b);
      r  = qs;
      e  = 1'b0;
    end
  endtask

  // Drive a one-cycle start pulse from the current negedge and queue the expectation.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input string name);
    exp_t e;
    e.res  = er;
    e.exc  = ee;
    e.due  = cyc + 34;
    e.name = name;
    sb.push_back(e);
    mdu_if.data_operandA = a;
    mdu_if.data_operandB = b;
    mdu_if.ctrl_MULT     = m;
    mdu_if.ctrl_DIV      = d;
    @(negedge clock);
    mdu_if.ctrl_MULT = 1'b0;
    mdu_if.ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && mdu_if.data_resultRDY === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_rdy", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_res"}, 64'(mdu_if.data_result), 64'(e.res));
          check({e.name, "_exc"}, 64'(mdu_if.data_exception), 64'(e.exc));
          check({e.name, "_lat"}, 64'(cyc), 64'(e.due));
          $display("txn %s: result=%08h exc=%0b cycle=%0d", e.name,
                   mdu_if.data_result, mdu_if.data_exception, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, er;
    logic        ee;
    bit          m;
    cyc       = 0;
    n_asserts = 0;
    n_fail    = 0;
    reset     = 1'b1;
    mdu_if.data_operandA = '0;
    mdu_if.data_operandB = '0;
    mdu_if.ctrl_MULT     = 1'b0;
    mdu_if.ctrl_DIV      = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_res", 64'(mdu_if.data_result), 64'd0);
      check("rst_exc", 64'(mdu_if.data_exception), 64'd0);
      check("rst_rdy", 64'(mdu_if.data_resultRDY), 64'd0);
    end
    reset = 1'b0;
    @(negedge clock);

    // 7 * -3, then result held
    start_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
    wait_done();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold_res", 64'(mdu_if.data_result), 64'hFFFF_FFEB);
      check("hold_rdy", 64'(mdu_if.data_resultRDY), 64'd0);
    end

    start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, "mul_ovf");
    wait_done();
    start_op(1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "mul_min");
    wait_done();
    start_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    wait_done();
    start_op(0, 1, 32'd5, 32'd0, 32'h0, 1'b1, "div_by0");
    wait_done();
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
    wait_done();

    // Start ignored mid-run; result cleared while running
    start_op(1, 0, 32'd6, 32'd7, 32'd42, 1'b0, "mul_6_7");
    repeat (9) @(negedge clock);
    check("run_res_clr", 64'(mdu_if.data_result), 64'd0);
    mdu_if.data_operandA = 32'd100;
    mdu_if.data_operandB = 32'd5;
    mdu_if.ctrl_DIV      = 1'b1;
    @(negedge clock);
    mdu_if.ctrl_DIV = 1'b0;
    wait_done();

    // Both starts together: multiply wins
    start_op(1, 1, 32'd9, 32'd3, 32'd27, 1'b0, "both_9_3");
    wait_done();

    // Back-to-back: second start in the DONE cycle
    start_op(1, 0, 32'd5, 32'd5, 32'd25, 1'b0, "b2b_first");
    for (int i = 0; i < 60 && mdu_if.data_resultRDY !== 1'b1; i++) @(negedge clock);
    check("b2b_rdy_seen", 64'(mdu_if.data_resultRDY), 64'd1);
    start_op(0, 1, 32'd100, 32'd7, 32'd14, 1'b0, "b2b_second");
    wait_done();

    // Reset mid-operation abandons it
    start_op(1, 0, 32'd1000, 32'd1000, 32'd1000000, 1'b0, "abandoned");
    repeat (14) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    check("midrst_res", 64'(mdu_if.data_result), 64'd0);
    check("midrst_exc", 64'(mdu_if.data_exception), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("midrst_rdy", 64'(mdu_if.data_resultRDY), 64'd0);
    end
    start_op(1, 0, 32'd3, 32'd4, 32'd12, 1'b0, "mul_3_4");
    wait_done();

    // A few random operands against the native-arithmetic model
    for (int i = 0; i < 8; i++) begin
      m  = i[0];
      ra = $urandom;
      rb = (i % 4 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 2) ra = 32'h0;
      if (i == 3) rb = -32'sd13;
      model(m, ra, rb, er, ee);
      start_op(m, !m, ra, rb, er, ee, m ? "rnd_mul" : "rnd_div");
      wait_done();
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
